l1_meta_array_arb: RTL and testbench

- Parametrised successor to the fixed L1 metadata read/write request channels (6-bit idx, 8 ways, 20-bit tag, 2-bit coh).
- Owns the L1 metadata storage (NSETS x NWAYS entries of {coh, tag}).
- Arbitrates one write channel and NREQ read requesters (e.g. writeback unit, probe unit, core pipeline).
- Returns all ways of the selected set one cycle after acceptance, with a per-way tag-hit vector.
- Self-initialises after reset by walking every set to the invalid state.

---
 rtl/l1_meta_array_arb_pkg.sv | 22 ++
 rtl/l1_meta_array_arb_rr_prio.sv | 25 ++
 rtl/l1_meta_array_arb.sv | 196 +++++++++++++++++++
 tb/tb_l1_meta_array_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_meta_array_arb_pkg.sv
// Shared constants and types for the L1 metadata array and its request arbiter.
package l1_meta_pkg;

  localparam int L1_NSETS = 64;
  localparam int L1_NWAYS = 8;
  localparam int L1_TAG_W = 20;
  localparam int L1_COH_W = 2;

  typedef enum logic [L1_COH_W-1:0] {
    COH_NOTHING = 2'd0,
    COH_BRANCH  = 2'd1,
    COH_TRUNK   = 2'd2,
    COH_DIRTY   = 2'd3
  } l1_coh_e;

  // Entry layout at the default geometry; the array redeclares it at its own widths.
  typedef struct packed {
    logic [L1_COH_W-1:0] coh;
    logic [L1_TAG_W-1:0] tag;
  } l1_meta_entry_t;

endpackage

// File: rtl/l1_meta_array_arb_rr_prio.sv
// Fixed-priority read grant: index 0 wins; any pending write blocks every read.
module l1_meta_rr_prio
  import l1_meta_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic            en,
  input  logic            block,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  logic higher;

  // A requester is offered the grant whether or not it is itself requesting.
  always_comb begin
    gnt    = '0;
    higher = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = en && !block && !higher;
      higher = higher | req[i];
    end
  end

endmodule

// File: rtl/l1_meta_array_arb.sv
// L1 metadata array with write-priority arbitration over NREQ readers and 1-cycle read response.
// Optional per-entry even parity is enabled by defining L1_META_PARITY_EN.
module l1_meta_array_arb
  import l1_meta_pkg::*;
#(
  parameter  int NSETS = L1_NSETS,
  parameter  int NWAYS = L1_NWAYS,
  parameter  int TAG_W = L1_TAG_W,
  parameter  int COH_W = L1_COH_W,
  parameter  int NREQ  = 3,
  localparam int IDX_W = $clog2(NSETS),
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         rd_req_valid,
  output logic [NREQ-1:0]         rd_req_ready,
  input  logic [NREQ*IDX_W-1:0]   rd_req_idx,
  input  logic [NREQ*TAG_W-1:0]   rd_req_tag,
  output logic                    rd_resp_valid,
  output logic [ID_W-1:0]         rd_resp_id,
  output logic [NWAYS*TAG_W-1:0]  rd_resp_tag,
  output logic [NWAYS*COH_W-1:0]  rd_resp_coh,
  output logic [NWAYS-1:0]        rd_resp_hit,
  output logic [NWAYS-1:0]        rd_resp_perr,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [IDX_W-1:0]        wr_req_idx,
  input  logic [NWAYS-1:0]        wr_req_way_en,
  input  logic [COH_W-1:0]        wr_req_coh,
  input  logic [TAG_W-1:0]        wr_req_tag,
`ifdef L1_META_PARITY_EN
  input  logic                    wr_req_perr_inject,
`endif
  output logic                    init_done
);

  typedef struct packed {
    logic [COH_W-1:0] coh;
    logic [TAG_W-1:0] tag;
  } meta_entry_t;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic       init_wr, run;

  meta_entry_t [NWAYS-1:0] mem_q [NSETS];
  meta_entry_t [NWAYS-1:0] wr_row, rd_row;

  logic [NREQ-1:0]  rd_fire;
  logic             wr_fire;
  logic [ID_W-1:0]  sel_id;
  logic [IDX_W-1:0] sel_idx;
  logic [TAG_W-1:0] sel_tag;

  logic             vld_p1;
  logic [ID_W-1:0]  id_p1;
  logic [IDX_W-1:0] idx_p1;
  logic [TAG_W-1:0] tag_p1;

`ifdef L1_META_PARITY_EN
  logic [NWAYS-1:0] par_q [NSETS];
  logic [NWAYS-1:0] wr_par, rd_par;

  function automatic logic even_par(input logic [COH_W-1:0] coh, input logic [TAG_W-1:0] tag);
    return ^{coh, tag};
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_wr = 1'b0;
    run     = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_wr = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(NSETS - 1)) state_d = ST_RUN;
      end
      ST_RUN:  run = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_done    = run;
  assign wr_req_ready = run;
  assign wr_fire      = wr_req_valid && run;

  l1_meta_rr_prio #(.NREQ(NREQ)) u_prio (
    .en    (run),
    .block (wr_req_valid),
    .req   (rd_req_valid),
    .gnt   (rd_req_ready)
  );

  assign rd_fire = rd_req_valid & rd_req_ready;

  always_comb begin
    sel_id  = '0;
    sel_idx = '0;
    sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rd_fire[i]) begin
        sel_id  = ID_W'(i);
        sel_idx = rd_req_idx[i*IDX_W +: IDX_W];
        sel_tag = rd_req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Whole-row read-modify-write keeps the array update a single indexed assignment.
  always_comb begin
    wr_row = mem_q[wr_req_idx];
    for (int w = 0; w < NWAYS; w++) begin
      if (wr_req_way_en[w]) wr_row[w] = {wr_req_coh, wr_req_tag};
    end
  end

`ifdef L1_META_PARITY_EN
  always_comb begin
    wr_par = par_q[wr_req_idx];
    for (int w = 0; w < NWAYS; w++) begin
      if (wr_req_way_en[w]) wr_par[w] = even_par(wr_req_coh, wr_req_tag) ^ wr_req_perr_inject;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (init_wr) begin
      mem_q[cnt_q] <= '0;
`ifdef L1_META_PARITY_EN
      par_q[cnt_q] <= '0;
`endif
    end else if (wr_fire) begin
      mem_q[wr_req_idx] <= wr_row;
`ifdef L1_META_PARITY_EN
      par_q[wr_req_idx] <= wr_par;
`endif
    end
  end

  // p1: response stage; data is read from the array during the response cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      id_p1  <= '0;
    end else begin
      vld_p1 <= |rd_fire;
      if (|rd_fire) id_p1 <= sel_id;
    end
  end

  always_ff @(posedge clock) begin
    if (|rd_fire) begin
      idx_p1 <= sel_idx;
      tag_p1 <= sel_tag;
    end
  end

  assign rd_row        = mem_q[idx_p1];
  assign rd_resp_valid = vld_p1;
  assign rd_resp_id    = id_p1;
`ifdef L1_META_PARITY_EN
  assign rd_par        = par_q[idx_p1];
`endif

  always_comb begin
    rd_resp_tag  = '0;
    rd_resp_coh  = '0;
    rd_resp_hit  = '0;
    rd_resp_perr = '0;
    for (int w = 0; w < NWAYS; w++) begin
      rd_resp_tag[w*TAG_W +: TAG_W] = rd_row[w].tag;
      rd_resp_coh[w*COH_W +: COH_W] = rd_row[w].coh;
      rd_resp_hit[w] = vld_p1 && (rd_row[w].tag == tag_p1) &&
                       (rd_row[w].coh != COH_W'(COH_NOTHING));
`ifdef L1_META_PARITY_EN
      rd_resp_perr[w] = vld_p1 && (even_par(rd_row[w].coh, rd_row[w].tag) != rd_par[w]);
`endif
    end
  end

endmodule

// File: tb/tb_l1_meta_array_arb.sv
// Randomised scoreboard bench for l1_meta_array_arb against an array-based reference model.
module tb_l1_meta_array_arb;

  localparam int NSETS = 64;
  localparam int NWAYS = 8;
  localparam int TAG_W = 20;
  localparam int COH_W = 2;
  localparam int NREQ  = 3;
  localparam int IDX_W = 6;
  localparam int ID_W  = 2;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        rd_req_valid;
  logic [NREQ-1:0]        rd_req_ready;
  logic [NREQ*IDX_W-1:0]  rd_req_idx;
  logic [NREQ*TAG_W-1:0]  rd_req_tag;
  logic                   rd_resp_valid;
  logic [ID_W-1:0]        rd_resp_id;
  logic [NWAYS*TAG_W-1:0] rd_resp_tag;
  logic [NWAYS*COH_W-1:0] rd_resp_coh;
  logic [NWAYS-1:0]       rd_resp_hit;
  logic [NWAYS-1:0]       rd_resp_perr;
  logic                   wr_req_valid;
  logic                   wr_req_ready;
  logic [IDX_W-1:0]       wr_req_idx;
  logic [NWAYS-1:0]       wr_req_way_en;
  logic [COH_W-1:0]       wr_req_coh;
  logic [TAG_W-1:0]       wr_req_tag;
  logic                   wr_inj;
  logic                   init_done;

  always #5 clock = ~clock;

  l1_meta_array_arb dut (
    .clock         (clock),
    .reset         (reset),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_idx    (rd_req_idx),
    .rd_req_tag    (rd_req_tag),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_id    (rd_resp_id),
    .rd_resp_tag   (rd_resp_tag),
    .rd_resp_coh   (rd_resp_coh),
    .rd_resp_hit   (rd_resp_hit),
    .rd_resp_perr  (rd_resp_perr),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_idx    (wr_req_idx),
    .wr_req_way_en (wr_req_way_en),
    .wr_req_coh    (wr_req_coh),
    .wr_req_tag    (wr_req_tag),
`ifdef L1_META_PARITY_EN
    .wr_req_perr_inject (wr_inj),
`endif
    .init_done     (init_done)
  );

  // Reference model: plain arrays of what each way should hold.
  logic [TAG_W-1:0] m_tag [NSETS][NWAYS];
  logic [COH_W-1:0] m_coh [NSETS][NWAYS];
  logic             m_inj [NSETS][NWAYS];
  bit known = 1'b0;
  bit run   = 1'b0;
  int init_cycles = 0;

  typedef struct {
    int                     due;
    int                     id;
    logic [NWAYS*TAG_W-1:0] tag;
    logic [NWAYS*COH_W-1:0] coh;
    logic [NWAYS-1:0]       hit;
    logic [NWAYS-1:0]       perr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_idle();
    rd_req_valid  = '0;
    wr_req_valid  = 1'b0;
    wr_req_way_en = '0;
    wr_inj        = 1'b0;
  endtask

  task automatic set_rd(input int i, input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag);
    rd_req_valid[i] = 1'b1;
    rd_req_idx[i*IDX_W +: IDX_W] = idx;
    rd_req_tag[i*TAG_W +: TAG_W] = tag;
  endtask

  task automatic set_wr(input logic [IDX_W-1:0] idx, input logic [NWAYS-1:0] way,
                        input logic [COH_W-1:0] coh, input logic [TAG_W-1:0] tag, input logic inj);
    wr_req_valid  = 1'b1;
    wr_req_idx    = idx;
    wr_req_way_en = way;
    wr_req_coh    = coh;
    wr_req_tag    = tag;
    wr_inj        = inj;
  endtask

  task automatic clear_model();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NWAYS; w++) begin
        m_tag[s][w] = '0;
        m_coh[s][w] = '0;
        m_inj[s][w] = 1'b0;
      end
  endtask

  // One clock: check grants before the edge, then advance the model at the edge.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int   winner;
    int   ridx;
    exp_t e;
    @(negedge clock);
    winner = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (rd_req_valid[i]) winner = i;
    if (known) begin
      for (int i = 0; i < NREQ; i++)
        exp_rdy[i] = run && !wr_req_valid && (winner < 0 || i <= winner);
      chk("ready", {init_done, wr_req_ready, rd_req_ready}, {run, run, exp_rdy});
    end
    @(posedge clock);
    if (reset) begin
      known = 1'b1;
      run = 1'b0;
      init_cycles = 0;
      clear_model();
    end else if (known && !run) begin
      init_cycles++;
      if (init_cycles == NSETS) run = 1'b1;
    end else if (known && wr_req_valid) begin
      for (int w = 0; w < NWAYS; w++)
        if (wr_req_way_en[w]) begin
          m_tag[wr_req_idx][w] = wr_req_tag;
          m_coh[wr_req_idx][w] = wr_req_coh;
`ifdef L1_META_PARITY_EN
          m_inj[wr_req_idx][w] = wr_inj;
`else
          m_inj[wr_req_idx][w] = 1'b0;
`endif
        end
    end else if (known && winner >= 0) begin
      ridx  = int'(rd_req_idx[winner*IDX_W +: IDX_W]);
      e.due = ncyc + 1;
      e.id  = winner;
      for (int w = 0; w < NWAYS; w++) begin
        e.tag[w*TAG_W +: TAG_W] = m_tag[ridx][w];
        e.coh[w*COH_W +: COH_W] = m_coh[ridx][w];
        e.hit[w]  = (m_tag[ridx][w] == rd_req_tag[winner*TAG_W +: TAG_W]) && (m_coh[ridx][w] != 0);
        e.perr[w] = m_inj[ridx][w];
      end
      exp_q.push_back(e);
    end
    #1;
  endtask

  always @(negedge clock) begin
    ncyc++;
    if (rd_resp_valid) begin
      if (exp_q.size() == 0 || exp_q[0].due != ncyc) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got valid=1 id=%0d expected no response (t=%0t)", rd_resp_id, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_id",   rd_resp_id,   mon_e.id[ID_W-1:0]);
        chk("resp_tag",  rd_resp_tag,  mon_e.tag);
        chk("resp_coh",  rd_resp_coh,  mon_e.coh);
        chk("resp_hit",  rd_resp_hit,  mon_e.hit);
        chk("resp_perr", rd_resp_perr, mon_e.perr);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= ncyc) begin
      checks++;
      errors++;
      $display("FAIL resp_missing: got valid=0 expected response id=%0d (t=%0t)", exp_q[0].id, $time);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    logic [TAG_W-1:0] pool [4];
    pool[0] = 20'h12345; pool[1] = 20'hABCDE; pool[2] = 20'h00000; pool[3] = 20'hFFFFF;
    rd_req_idx = '0;
    rd_req_tag = '0;
    wr_req_idx = '0;
    wr_req_coh = '0;
    wr_req_tag = '0;
    set_idle();
    clear_model();

    reset = 1'b1;
    repeat (3) step();
    chk("rst_valid", rd_resp_valid, 1'b0);
    chk("rst_id",    rd_resp_id,    '0);
    chk("rst_hit",   rd_resp_hit,   '0);
    chk("rst_perr",  rd_resp_perr,  '0);
    chk("rst_init",  init_done,     1'b0);
    reset = 1'b0;
    repeat (NSETS) step();

    set_rd(0, 6'd63, 20'h0); step(); set_idle(); step();

    set_wr(6'd5, 8'h04, 2'd3, 20'hABCDE, 1'b0); step(); set_idle();
    set_rd(1, 6'd5, 20'hABCDE); step(); set_idle(); step();

    set_rd(0, 6'd5, 20'hABCDE); set_rd(2, 6'd5, 20'h11111); step();
    rd_req_valid[0] = 1'b0; step(); set_idle(); step();

    set_wr(6'd9, 8'h01, 2'd2, 20'h0BEEF, 1'b0); set_rd(0, 6'd9, 20'h0BEEF);
    repeat (3) step();
    wr_req_valid = 1'b0; step(); set_idle(); step();

    set_wr(6'd0, 8'hFF, 2'd1, 20'h12345, 1'b0); step(); set_idle();
    set_rd(0, 6'd0, 20'h12345); step(); set_idle();
    set_wr(6'd0, 8'h00, 2'd0, 20'h00000, 1'b0); step(); set_idle();
    set_rd(2, 6'd0, 20'h12345); step(); set_idle(); step();

`ifdef L1_META_PARITY_EN
    set_wr(6'd7, 8'h0A, 2'd2, 20'h55555, 1'b1); step(); set_idle();
    set_rd(1, 6'd7, 20'h55555); step(); set_idle(); step();
`endif

    for (int c = 0; c < 1500; c++) begin
      set_idle();
      rd_req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        rd_req_idx[i*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 7));
        rd_req_tag[i*TAG_W +: TAG_W] = pool[$urandom_range(0, 3)];
      end
      if ($urandom_range(0, 3) == 0)
        set_wr(IDX_W'($urandom_range(0, 7)), NWAYS'($urandom_range(0, 255)),
               COH_W'($urandom_range(0, 3)), pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
      step();
    end

    set_idle();
    set_rd(1, 6'd5, 20'hABCDE); step(); set_idle();
    reset = 1'b1; step();
    chk("midrst_valid", rd_resp_valid, 1'b0);
    chk("midrst_init",  init_done,     1'b0);
    reset = 1'b0;
    repeat (NSETS) step();
    set_rd(0, 6'd5, 20'hABCDE); step(); set_idle(); step(); step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
